// File: rtl/trap_scheduler.sv
// trap_scheduler: collects trap events from NUM_SRC sources into sticky pending bits, picks
// one by fixed priority (bit 0 highest), drives a timed active-low NMI pulse and tracks
// supervisor entry/exit through trap_state, followed by a dispatch hold-off.
// Optional feature: define TRAP_VTIMER_EN to OR a free-running virtual timer tick
// (period TICK_DIV) into source NUM_SRC-1.
module trap_scheduler #(
  parameter int unsigned NUM_SRC       = 4,
  parameter int unsigned NMI_WIDTH     = 4,
  parameter int unsigned ENTRY_TIMEOUT = 255,
  parameter int unsigned HOLDOFF       = 8,
  parameter int unsigned TICK_DIV      = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] trap_req,
  input  logic [NUM_SRC-1:0] trap_enable,
  input  logic               trap_state,
  input  logic               cause_ack,
  output logic               nmi_n,
  output logic [7:0]         cause_data,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);

  // One shared down-counter serves the pulse, entry-timeout and hold-off phases.
  localparam int unsigned CntMax0 = (NMI_WIDTH > ENTRY_TIMEOUT) ? NMI_WIDTH : ENTRY_TIMEOUT;
  localparam int unsigned CntMax  = (CntMax0 > HOLDOFF) ? CntMax0 : HOLDOFF;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] NmiLoad   = CntW'(NMI_WIDTH - 1);
  localparam logic [CntW-1:0] EntryLoad = CntW'(ENTRY_TIMEOUT - 1);
  localparam logic [CntW-1:0] HoldLoad  = CntW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [2:0] {StIdle, StPulse, StWaitEntry, StService, StHoldoff} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               nmi_q;
  logic [2:0]         cause_q;
  logic               ovf_q;
  logic               err_q;
  logic               active_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] ovf_src_q, ovf_src_d;
  logic [NUM_SRC-1:0] req_eff;
  logic [NUM_SRC-1:0] elig, win_oh, cause_oh, clr, set;
  logic [2:0]         win_idx;
  logic               dispatch, timeout;

`ifdef TRAP_VTIMER_EN
  localparam int unsigned TmrW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TmrW-1:0] tmr_q;
  logic            tmr_wrap;

  assign tmr_wrap = (tmr_q == TmrW'(TICK_DIV - 1));

  // Free-running virtual timer; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q <= '0;
    end else if (tmr_wrap) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  // Timer tick merges into the lowest-priority source.
  always_comb begin
    req_eff              = trap_req;
    req_eff[NUM_SRC-1]   = trap_req[NUM_SRC-1] | tmr_wrap;
  end
`else
  logic [31:0] unused_tick_div;
  assign unused_tick_div = TICK_DIV;
  assign req_eff         = trap_req;
`endif

  // Winner selection and pending set/clear vectors.
  always_comb begin
    elig     = pend_q & trap_enable;
    win_oh   = elig & (~elig + {{(NUM_SRC-1){1'b0}}, 1'b1});
    win_idx  = '0;
    cause_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_oh[i]) win_idx = 3'(i);
      cause_oh[i] = (cause_q == 3'(i));
    end
    dispatch  = (state_q == StIdle) && (|elig);
    timeout   = (state_q == StWaitEntry) && !trap_state && (cnt_q == '0);
    clr       = dispatch ? win_oh : '0;
    // A request landing on a bit being cleared is a fresh event: it sets but never overflows.
    set       = req_eff | (timeout ? cause_oh : '0);
    pend_d    = (pend_q & ~clr) | set;
    ovf_src_d = (ovf_src_q & ~clr) | (req_eff & pend_q & ~clr);
  end

  // Sticky pending and per-source overflow bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= '0;
      ovf_src_q <= '0;
    end else begin
      pend_q    <= pend_d;
      ovf_src_q <= ovf_src_d;
    end
  end

  // Dispatch sequencer with registered NMI and cause fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      nmi_q    <= 1'b1;
      cause_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      // Acknowledge first so that set conditions below take precedence.
      if (cause_ack) begin
        ovf_q <= 1'b0;
        err_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (dispatch) begin
            cause_q  <= win_idx;
            ovf_q    <= |(ovf_src_q & win_oh);
            active_q <= 1'b1;
            cnt_q    <= NmiLoad;
            nmi_q    <= 1'b0;
            state_q  <= StPulse;
          end
        end
        StPulse: begin
          if (cnt_q == '0) begin
            cnt_q   <= EntryLoad;
            nmi_q   <= 1'b1;
            state_q <= StWaitEntry;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWaitEntry: begin
          if (trap_state) begin
            state_q <= StService;
          end else if (cnt_q == '0) begin
            err_q    <= 1'b1;
            active_q <= 1'b0;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StService: begin
          if (!trap_state) begin
            active_q <= 1'b0;
            if (HOLDOFF == 0) begin
              state_q <= StIdle;
            end else begin
              cnt_q   <= HoldLoad;
              state_q <= StHoldoff;
            end
          end
        end
        StHoldoff: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign nmi_n      = nmi_q;
  assign cause_data = {active_q, ovf_q, err_q, 2'b00, cause_q};
  assign pending    = pend_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_trap_scheduler.sv
// Self-checking bench for trap_scheduler (default build, TRAP_VTIMER_EN undefined).
module tb_trap_scheduler;
  localparam int NmiWidth = 4;
  localparam int EntryTimeout = 255;
  localparam int Holdoff = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] trap_req, trap_enable;
  logic       trap_state, cause_ack;
  logic       nmi_n;
  logic [7:0] cause_data;
  logic [3:0] pending;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model: pending and overflow bits per source.
  logic [3:0] m_pend, m_ovf;

  always #5 clk = ~clk;

  trap_scheduler #(
    .NUM_SRC(4), .NMI_WIDTH(NmiWidth), .ENTRY_TIMEOUT(EntryTimeout), .HOLDOFF(Holdoff),
    .TICK_DIV(1024)
  ) dut (
    .clk(clk), .reset(reset), .trap_req(trap_req), .trap_enable(trap_enable),
    .trap_state(trap_state), .cause_ack(cause_ack), .nmi_n(nmi_n), .cause_data(cause_data),
    .pending(pending), .busy(busy)
  );

  function automatic logic [7:0] exp_cd(input logic act, input logic ov, input logic er,
                                        input int c);
    logic [2:0] c3;
    c3 = 3'(c);
    return {act, ov, er, 2'b00, c3};
  endfunction

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // One-cycle request; model applies the set/overflow rule (no dispatch clear assumed).
  task automatic req_pulse(input logic [3:0] r);
    trap_req = r;
    @(negedge clk);
    trap_req = '0;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        if (m_pend[i]) m_ovf[i] = 1'b1;
        m_pend[i] = 1'b1;
      end
    end
  endtask

  task automatic model_dispatch(input int w);
    m_pend[w] = 1'b0;
    m_ovf[w]  = 1'b0;
  endtask

  task automatic wait_nmi_low(input int bound, output int lat);
    lat = 0;
    while (nmi_n !== 1'b0 && lat < bound) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic measure_low(output int w);
    w = 0;
    while (nmi_n === 1'b0 && w < 100) begin
      w++;
      @(negedge clk);
    end
  endtask

  task automatic serve(input int pre, input int hold);
    repeat (pre) @(negedge clk);
    trap_state = 1'b1;
    repeat (hold) @(negedge clk);
    trap_state = 1'b0;
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (busy !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; trap_req = '0; trap_enable = '0; trap_state = 1'b0; cause_ack = 1'b0;
    m_pend = '0; m_ovf = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL reset_nmi: got %b want 1", nmi_n); end
    checks++; if (cause_data !== 8'h00) begin errors++; $display("FAIL reset_cause: got %h want 00", cause_data); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_dispatch;
    int lat, w, k;
    trap_enable = 4'hF;
    req_pulse(4'b0010);
    checks++; if (pending !== m_pend) begin errors++; $display("FAIL t1_pend: got %h want %h", pending, m_pend); end
    wait_nmi_low(10, lat);
    model_dispatch(1);
    checks++; if (lat !== 1) begin errors++; $display("FAIL t1_latency: got %0d want 1", lat); end
    checks++; if (cause_data !== 8'h81) begin errors++; $display("FAIL t1_cause: got %h want 81", cause_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", busy); end
    checks++; if (pending !== m_pend) begin errors++; $display("FAIL t1_pend_clr: got %h want %h", pending, m_pend); end
    measure_low(w);
    checks++; if (w !== NmiWidth) begin errors++; $display("FAIL t1_width: got %0d want %0d", w, NmiWidth); end
    serve(2, 3);
    @(negedge clk);
    checks++; if (cause_data !== 8'h01) begin errors++; $display("FAIL t1_exit_cause: got %h want 01", cause_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_holdoff_busy: got %b want 1", busy); end
    wait_idle(k);
    checks++; if (k !== Holdoff) begin errors++; $display("FAIL t1_holdoff_len: got %0d want %0d", k, Holdoff); end
  endtask

  task automatic test_priority;
    int lat, w, k;
    req_pulse(4'b1010);
    wait_nmi_low(10, lat);
    model_dispatch(1);
    checks++; if (cause_data !== 8'h81) begin errors++; $display("FAIL t2_first: got %h want 81", cause_data); end
    measure_low(w);
    serve(1, 2);
    wait_nmi_low(50, lat);
    model_dispatch(3);
    checks++; if (lat !== Holdoff + 2) begin errors++; $display("FAIL t2_gap: got %0d want %0d", lat, Holdoff + 2); end
    checks++; if (cause_data !== 8'h83) begin errors++; $display("FAIL t2_second: got %h want 83", cause_data); end
    checks++; if (pending !== m_pend) begin errors++; $display("FAIL t2_pend: got %h want %h", pending, m_pend); end
    measure_low(w);
    serve(0, 2);
    wait_idle(k);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_idle: got %b want 0", busy); end
  endtask

  task automatic test_overflow_mask;
    int lat, w, k;
    trap_enable = 4'b1011;
    req_pulse(4'b0100);
    @(negedge clk);
    req_pulse(4'b0100);
    repeat (3) @(negedge clk);
    checks++; if (pending !== m_pend) begin errors++; $display("FAIL t3_masked_pend: got %h want %h", pending, m_pend); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_masked_busy: got %b want 0", busy); end
    trap_enable = 4'hF;
    wait_nmi_low(10, lat);
    checks++; if (cause_data !== exp_cd(1'b1, m_ovf[2], 1'b0, 2)) begin errors++; $display("FAIL t3_ovf_cause: got %h want %h", cause_data, exp_cd(1'b1, m_ovf[2], 1'b0, 2)); end
    model_dispatch(2);
    cause_ack = 1'b1;
    @(negedge clk);
    cause_ack = 1'b0;
    checks++; if (cause_data !== 8'h82) begin errors++; $display("FAIL t3_ack: got %h want 82", cause_data); end
    measure_low(w);
    serve(1, 1);
    wait_idle(k);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_idle: got %b want 0", busy); end
  endtask

  task automatic test_set_clear_collision;
    int lat, w, k;
    trap_req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    trap_req = '0;
    checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL t_col_nmi: got %b want 0", nmi_n); end
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL t_col_pend: got %h want 1", pending); end
    measure_low(w);
    serve(0, 1);
    wait_nmi_low(50, lat);
    checks++; if (cause_data !== 8'h80) begin errors++; $display("FAIL t_col_no_ovf: got %h want 80", cause_data); end
    measure_low(w);
    serve(0, 1);
    wait_idle(k);
    checks++; if (pending !== m_pend) begin errors++; $display("FAIL t_col_final: got %h want %h", pending, m_pend); end
  endtask

  task automatic test_entry_timeout;
    int lat, w, k;
    req_pulse(4'b0001);
    wait_nmi_low(10, lat);
    checks++; if (cause_data !== 8'h80) begin errors++; $display("FAIL t4_cause: got %h want 80", cause_data); end
    measure_low(w);
    k = 0;
    while (cause_data[5] !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k !== EntryTimeout) begin errors++; $display("FAIL t4_timeout_len: got %0d want %0d", k, EntryTimeout); end
    checks++; if (cause_data !== 8'h20) begin errors++; $display("FAIL t4_err_cause: got %h want 20", cause_data); end
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL t4_repend: got %h want 1", pending); end
    @(negedge clk);
    checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL t4_redispatch: got %b want 0", nmi_n); end
    checks++; if (cause_data !== 8'hA0) begin errors++; $display("FAIL t4_redispatch_cause: got %h want a0", cause_data); end
    model_dispatch(0);
    cause_ack = 1'b1;
    @(negedge clk);
    cause_ack = 1'b0;
    checks++; if (cause_data !== 8'h80) begin errors++; $display("FAIL t4_ack: got %h want 80", cause_data); end
    measure_low(w);
    serve(0, 2);
    wait_idle(k);
    checks++; if (pending !== m_pend) begin errors++; $display("FAIL t4_final_pend: got %h want %h", pending, m_pend); end
  endtask

  task automatic test_random;
    int lat, w, k, n, src;
    logic [3:0] mask, r;
    for (int round = 0; round < 8; round++) begin
      trap_enable = '0;
      n = int'($urandom_range(3, 12));
      for (int j = 0; j < n; j++) begin
        r = 4'($urandom_range(0, 15));
        req_pulse(r);
      end
      wait_idle(k);
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_pend r%0d: got %h want %h", round, pending, m_pend); end
      mask = (round == 7) ? 4'hF : 4'($urandom_range(0, 15));
      trap_enable = mask;
      while ((m_pend & mask) != '0) begin
        src = lowest(m_pend & mask);
        wait_nmi_low(40, lat);
        checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL rnd_nmi r%0d: got %b want 0", round, nmi_n); end
        checks++; if (cause_data !== exp_cd(1'b1, m_ovf[src], 1'b0, src)) begin errors++; $display("FAIL rnd_cause r%0d: got %h want %h", round, cause_data, exp_cd(1'b1, m_ovf[src], 1'b0, src)); end
        model_dispatch(src);
        measure_low(w);
        checks++; if (w !== NmiWidth) begin errors++; $display("FAIL rnd_width r%0d: got %0d want %0d", round, w, NmiWidth); end
        cause_ack = 1'b1;
        @(negedge clk);
        cause_ack = 1'b0;
        serve(int'($urandom_range(0, 5)), int'($urandom_range(1, 6)));
      end
      wait_idle(k);
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_left r%0d: got %h want %h", round, pending, m_pend); end
    end
  endtask

  task automatic test_reset_mid_pulse;
    int lat;
    trap_enable = 4'b0111;
    req_pulse(4'b1001);
    wait_nmi_low(10, lat);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL t5_async_nmi: got %b want 1", nmi_n); end
    m_pend = '0; m_ovf = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL t5_pend: got %h want 0", pending); end
    checks++; if (cause_data !== 8'h00) begin errors++; $display("FAIL t5_cause: got %h want 00", cause_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_dispatch();
    test_priority();
    test_overflow_mask();
    test_set_clear_collision();
    test_entry_timeout();
    test_random();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
